// File: rtl/rc5_pkg.sv
// Shared types and constants for the RC5 key-schedule / block controller and its datapath.
package rc5_pkg;

    localparam int ROUNDS_DEF    = 12;
    localparam int KEY_WORDS_DEF = 4;
    localparam int T_DEF         = 2 * ROUNDS_DEF + 2;

    // Magic constants consumed by the datapath when it builds the S table.
    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY_INIT,
        ST_KEY_MIX,
        ST_READY,
        ST_PRE,
        ST_ROUND,
        ST_POST,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_S_INIT  = 3'd1,
        OP_MIX     = 3'd2,
        OP_PRE     = 3'd3,
        OP_ENC_RND = 3'd4,
        OP_DEC_RND = 3'd5,
        OP_POST    = 3'd6
    } dp_op_t;

    function automatic int mix_cycles(input int t, input int kw);
        return 3 * ((t > kw) ? t : kw);
    endfunction

endpackage

// File: rtl/rc5_if.sv
// Command/status bundle between the host (master) and the RC5 controller (slave).
interface rc5_if;

    logic             key_load;
    logic             encrypt;
    logic             decrypt;
    logic             start;

    logic             start_ready;
    logic             key_valid;
    logic             busy;
    logic             done;
    logic             err;
    rc5_pkg::dp_op_t  dp_op;
    logic [4:0]       s_idx;
    logic [1:0]       l_idx;
    logic [3:0]       pair_idx;
    logic             s_we;
    logic             l_we;

    modport master (
        output key_load, encrypt, decrypt, start,
        input  start_ready, key_valid, busy, done, err,
        input  dp_op, s_idx, l_idx, pair_idx, s_we, l_we
    );

    modport slave (
        input  key_load, encrypt, decrypt, start,
        output start_ready, key_valid, busy, done, err,
        output dp_op, s_idx, l_idx, pair_idx, s_we, l_we
    );

endinterface

// File: rtl/rc5_wrap_cnt.sv
// Modulo-MOD up/down counter; o_wrap flags the enabled step that wraps (MOD-1 -> 0 or 0 -> MOD-1).
module rc5_wrap_cnt #(
    parameter int MOD = 26,
    parameter int W   = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_down,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    logic [W-1:0] r_cnt;

    assign o_wrap = i_en && (i_down ? (r_cnt == '0) : (r_cnt == LAST));
    assign o_cnt  = r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            if (o_wrap) r_cnt <= i_down ? LAST : '0;
            else        r_cnt <= i_down ? (r_cnt - ONE) : (r_cnt + ONE);
        end
    end

endmodule

// File: rtl/rc5_ctrl.sv
// RC5 controller: sequences key expansion and block rounds for an external datapath.
module rc5_ctrl
    import rc5_pkg::*;
#(
    parameter int ROUNDS    = ROUNDS_DEF,
    parameter int KEY_WORDS = KEY_WORDS_DEF
) (
    input  logic    clk,
    input  logic    rst,
    rc5_if.slave    bus
);

    localparam int         T          = 2 * ROUNDS + 2;
    localparam int         MIX_CYC    = mix_cycles(T, KEY_WORDS);
    localparam int         CYC_W      = $clog2(MIX_CYC);
    localparam logic [3:0] PAIR_LAST  = 4'(ROUNDS);
    localparam logic [3:0] PAIR_FIRST = 4'd1;

    state_t r_state, w_state_nxt;
    logic   r_dir_dec, w_dir_dec_nxt;
    logic   w_err_nxt, w_key_start, w_blk_start, w_idle_nxt;
    dp_op_t r_dp_op, w_dp_op_nxt;

    logic r_s_we, r_l_we, r_busy, r_done, r_err, r_start_ready, r_key_valid;

    logic [4:0]       w_s_idx;
    logic [1:0]       w_l_idx;
    logic [3:0]       w_pair_idx;
    logic [CYC_W-1:0] w_cyc_cnt_unused;
    logic             w_s_wrap, w_l_wrap_unused, w_pair_wrap, w_cyc_wrap;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_dir_dec_nxt = r_dir_dec;
        w_err_nxt     = 1'b0;
        w_key_start   = 1'b0;
        w_blk_start   = 1'b0;
        case (r_state)
            ST_IDLE, ST_READY: begin
                // key_load beats start; key_valid is only ever set while in READY here.
                if (bus.key_load) begin
                    w_state_nxt = ST_KEY_INIT;
                    w_key_start = 1'b1;
                end else if (bus.start) begin
                    if (r_key_valid && (bus.encrypt ^ bus.decrypt)) begin
                        w_blk_start   = 1'b1;
                        w_dir_dec_nxt = bus.decrypt;
                        w_state_nxt   = bus.decrypt ? ST_ROUND : ST_PRE;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_KEY_INIT: if (w_s_wrap)   w_state_nxt = ST_KEY_MIX;
            ST_KEY_MIX:  if (w_cyc_wrap) w_state_nxt = ST_READY;
            ST_PRE:      w_state_nxt = ST_ROUND;
            ST_ROUND: begin
                if (!r_dir_dec && w_pair_wrap)              w_state_nxt = ST_DONE;
                else if (r_dir_dec && w_pair_idx == PAIR_FIRST) w_state_nxt = ST_POST;
            end
            ST_POST:     w_state_nxt = ST_DONE;
            ST_DONE:     w_state_nxt = ST_READY;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_dp_op_nxt = OP_NOP;
        case (w_state_nxt)
            ST_KEY_INIT: w_dp_op_nxt = OP_S_INIT;
            ST_KEY_MIX:  w_dp_op_nxt = OP_MIX;
            ST_PRE:      w_dp_op_nxt = OP_PRE;
            ST_ROUND:    w_dp_op_nxt = w_dir_dec_nxt ? OP_DEC_RND : OP_ENC_RND;
            ST_POST:     w_dp_op_nxt = OP_POST;
            default:     w_dp_op_nxt = OP_NOP;
        endcase
    end

    assign w_idle_nxt = w_state_nxt inside {ST_IDLE, ST_READY, ST_DONE};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_dir_dec <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dir_dec <= w_dir_dec_nxt;
        end
    end

    // Status and strobes are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dp_op       <= OP_NOP;
            r_s_we        <= 1'b0;
            r_l_we        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_start_ready <= 1'b0;
            r_key_valid   <= 1'b0;
        end else begin
            r_dp_op       <= w_dp_op_nxt;
            r_s_we        <= w_state_nxt inside {ST_KEY_INIT, ST_KEY_MIX};
            r_l_we        <= (w_state_nxt == ST_KEY_MIX);
            r_busy        <= !(w_state_nxt inside {ST_IDLE, ST_READY});
            r_done        <= (w_state_nxt == ST_DONE);
            r_err         <= w_err_nxt;
            r_start_ready <= (w_state_nxt == ST_READY);
            r_key_valid   <= w_state_nxt inside {ST_READY, ST_PRE, ST_ROUND, ST_POST, ST_DONE};
        end
    end

    // s_idx runs straight through INIT into MIX; its T-1 -> 0 wrap marks the INIT/MIX boundary.
    rc5_wrap_cnt #(.MOD(T), .W(5)) u_s_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_key_start || w_idle_nxt),
        .i_load     (1'b0),
        .i_load_val (5'd0),
        .i_en       (r_state inside {ST_KEY_INIT, ST_KEY_MIX}),
        .i_down     (1'b0),
        .o_cnt      (w_s_idx),
        .o_wrap     (w_s_wrap)
    );

    rc5_wrap_cnt #(.MOD(KEY_WORDS), .W(2)) u_l_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_key_start || w_idle_nxt),
        .i_load     (1'b0),
        .i_load_val (2'd0),
        .i_en       (r_state == ST_KEY_MIX),
        .i_down     (1'b0),
        .o_cnt      (w_l_idx),
        .o_wrap     (w_l_wrap_unused)
    );

    rc5_wrap_cnt #(.MOD(ROUNDS + 1), .W(4)) u_pair_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_key_start || w_idle_nxt),
        .i_load     (w_blk_start),
        .i_load_val (w_dir_dec_nxt ? PAIR_LAST : 4'd0),
        .i_en       (r_state inside {ST_PRE, ST_ROUND}),
        .i_down     (r_dir_dec),
        .o_cnt      (w_pair_idx),
        .o_wrap     (w_pair_wrap)
    );

    rc5_wrap_cnt #(.MOD(MIX_CYC), .W(CYC_W)) u_cyc_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (r_state != ST_KEY_MIX),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (1'b1),
        .i_down     (1'b0),
        .o_cnt      (w_cyc_cnt_unused),
        .o_wrap     (w_cyc_wrap)
    );

    assign bus.dp_op       = r_dp_op;
    assign bus.s_idx       = w_s_idx;
    assign bus.l_idx       = w_l_idx;
    assign bus.pair_idx    = w_pair_idx;
    assign bus.s_we        = r_s_we;
    assign bus.l_we        = r_l_we;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.start_ready = r_start_ready;
    assign bus.key_valid   = r_key_valid;

endmodule

// File: tb/tb_rc5_ctrl.sv
// Scoreboard bench for rc5_ctrl: per-cycle expected output vectors are queued with each command.
module tb_rc5_ctrl;
    import rc5_pkg::*;

    localparam int R   = ROUNDS_DEF;
    localparam int KW  = KEY_WORDS_DEF;
    localparam int T   = 2 * R + 2;
    localparam int MIX = 3 * T;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rc5_if bus();

    rc5_ctrl #(.ROUNDS(R), .KEY_WORDS(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] s;
        logic [1:0] l;
        logic [3:0] p;
        logic       swe, lwe, busy, done, err, kv, rdy;
    } vec_t;

    typedef struct {
        vec_t val;
        vec_t mask;
    } exp_t;

    exp_t  sb[$];
    int    n_vec   = 0;
    int    n_miss  = 0;
    int    step_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t observe();
        vec_t v;
        v.op   = bus.dp_op;
        v.s    = bus.s_idx;
        v.l    = bus.l_idx;
        v.p    = bus.pair_idx;
        v.swe  = bus.s_we;
        v.lwe  = bus.l_we;
        v.busy = bus.busy;
        v.done = bus.done;
        v.err  = bus.err;
        v.kv   = bus.key_valid;
        v.rdy  = bus.start_ready;
        return v;
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input int s, input int l, input int p,
                                input logic swe, input logic lwe, input logic busy,
                                input logic done, input logic err, input logic kv, input logic rdy);
        vec_t v;
        v.op = op; v.s = 5'(s); v.l = 2'(l); v.p = 4'(p);
        v.swe = swe; v.lwe = lwe; v.busy = busy; v.done = done;
        v.err = err; v.kv = kv; v.rdy = rdy;
        return v;
    endfunction

    // Index fields the controller leaves unspecified in a given state are masked out.
    function automatic vec_t care(input bit s_c, input bit l_c, input bit p_c);
        vec_t m;
        m = '1;
        if (!s_c) m.s = '0;
        if (!l_c) m.l = '0;
        if (!p_c) m.p = '0;
        return m;
    endfunction

    task automatic push(input vec_t v, input vec_t m);
        exp_t e;
        e.val  = v;
        e.mask = m;
        sb.push_back(e);
    endtask

    task automatic push_idle(input logic err);
        push(mk(OP_NOP, 0, 0, 0, 0, 0, 0, 0, err, 0, 0), care(1, 1, 1));
    endtask

    task automatic push_ready(input logic err);
        push(mk(OP_NOP, 0, 0, 0, 0, 0, 0, 0, err, 1, 1), care(0, 0, 0));
    endtask

    task automatic push_done();
        push(mk(OP_NOP, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0), care(0, 0, 0));
    endtask

    task automatic push_keyexp();
        for (int c = 0; c < T; c++)
            push(mk(OP_S_INIT, c, 0, 0, 1, 0, 1, 0, 0, 0, 0), care(1, 0, 0));
        for (int m = 0; m < MIX; m++)
            push(mk(OP_MIX, m % T, m % KW, 0, 1, 1, 1, 0, 0, 0, 0), care(1, 1, 0));
        push_ready(0);
    endtask

    task automatic push_enc();
        push(mk(OP_PRE, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), care(0, 0, 1));
        for (int k = 1; k <= R; k++)
            push(mk(OP_ENC_RND, 0, 0, k, 0, 0, 1, 0, 0, 1, 0), care(0, 0, 1));
        push_done();
        push_ready(0);
    endtask

    task automatic push_dec();
        for (int k = R; k >= 1; k--)
            push(mk(OP_DEC_RND, 0, 0, k, 0, 0, 1, 0, 0, 1, 0), care(0, 0, 1));
        push(mk(OP_POST, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), care(0, 0, 1));
        push_done();
        push_ready(0);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        step_no++;
        if (sb.size() == 0) begin
            check($sformatf("%s c%0d sb_empty", tag, step_no), 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s c%0d", tag, step_no),
                  32'(observe() & e.mask), 32'(e.val & e.mask));
        end
    endtask

    task automatic pulse(input string tag, input logic kl, input logic st,
                         input logic en, input logic de);
        bus.key_load = kl;
        bus.start    = st;
        bus.encrypt  = en;
        bus.decrypt  = de;
        step(tag);
        bus.key_load = 1'b0;
        bus.start    = 1'b0;
        bus.encrypt  = 1'b0;
        bus.decrypt  = 1'b0;
    endtask

    task automatic run(input string tag, input int n);
        repeat (n) step(tag);
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) step(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_load = 1'b0;
        bus.start    = 1'b0;
        bus.encrypt  = 1'b0;
        bus.decrypt  = 1'b0;

        #2 rst = 1'b0;
        #2;
        check("reset_state", 32'(observe()), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // No key yet: start is an error and the controller stays in IDLE.
        push_idle(1); push_idle(0);
        step_no = 0; pulse("idle_err_enc", 0, 1, 1, 0); drain("idle_err_enc");
        push_idle(1); push_idle(0);
        step_no = 0; pulse("idle_err_none", 0, 1, 0, 0); drain("idle_err_none");

        // Full expansion; a start mid-expansion must be ignored.
        push_keyexp();
        step_no = 0; pulse("keyexp", 1, 0, 0, 0);
        run("keyexp", 40);
        pulse("keyexp_ign_start", 0, 1, 1, 0);
        drain("keyexp");

        // Encrypt; a key_load mid-block must be ignored.
        push_enc();
        step_no = 0; pulse("enc", 0, 1, 1, 0);
        run("enc", 4);
        pulse("enc_ign_kl", 1, 0, 0, 0);
        drain("enc");

        push_dec();
        step_no = 0; pulse("dec", 0, 1, 0, 1); drain("dec");

        push_ready(1); push_ready(0);
        step_no = 0; pulse("rdy_err_both", 0, 1, 1, 1); drain("rdy_err_both");
        push_ready(1); push_ready(0);
        step_no = 0; pulse("rdy_err_none", 0, 1, 0, 0); drain("rdy_err_none");

        // key_load and start together in READY: re-expansion wins.
        push_keyexp();
        step_no = 0; pulse("kl_and_start", 1, 1, 1, 0); drain("kl_and_start");

        // Reset in the middle of round 6 of an encrypt.
        push_enc();
        step_no = 0; pulse("enc_rst", 0, 1, 1, 0);
        run("enc_rst", 6);
        rst = 1'b0;
        #1;
        check("rst_mid_round", 32'(observe()), 32'd0);
        sb.delete();
        @(negedge clk);
        check("rst_hold", 32'(observe()), 32'd0);
        rst = 1'b1;

        push_keyexp();
        step_no = 0; pulse("kl_after_rst", 1, 0, 0, 0); drain("kl_after_rst");

        push_dec();
        step_no = 0; pulse("dec2", 0, 1, 0, 1); drain("dec2");

        check("sb_left", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
